// File: rtl/inv_lane_pkg.sv
// Shared constants and types for the inverting lane arbiter.
package inv_lane_pkg;

  localparam int NUM_CH = 5;
  localparam int ID_W   = 3;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  localparam logic [ID_W-1:0] CH_A = 3'd0;
  localparam logic [ID_W-1:0] CH_B = 3'd1;
  localparam logic [ID_W-1:0] CH_C = 3'd2;
  localparam logic [ID_W-1:0] CH_D = 3'd3;
  localparam logic [ID_W-1:0] CH_E = 3'd4;

endpackage

// File: rtl/inv_lane_arbiter_rr_pick5.sv
// Combinational rotate-priority picker over five requesters: the search
// starts at ptr_i and wraps from channel E back to channel A.
module rr_pick5
  import inv_lane_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [ID_W-1:0]   ptr_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [ID_W-1:0]   id_o,
  output logic              any_o
);

  logic [ID_W-1:0] base;
  logic [ID_W:0]   idx;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    idx   = '0;
    // An out-of-range pointer cannot occur, but falls back to channel A.
    base  = (ptr_i > CH_E) ? CH_A : ptr_i;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, base} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_CH)) idx = idx - (ID_W+1)'(NUM_CH);
      if (en_i && !any_o && req_i[idx[ID_W-1:0]]) begin
        gnt_o[idx[ID_W-1:0]] = 1'b1;
        id_o                 = idx[ID_W-1:0];
        any_o                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inv_lane_arbiter.sv
// Five-channel round-robin arbiter onto one inverting lane with a two-entry
// response FIFO. Optional per-entry parity is enabled by INV_LANE_PARITY_EN.
module inv_lane_arbiter
  import inv_lane_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   req,
  input  logic [NUM_CH*W-1:0] req_data,
  output logic [NUM_CH-1:0]   gnt,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [W-1:0]        rsp_data
`ifdef INV_LANE_PARITY_EN
  ,
  output logic                rsp_par
`endif
);

  buf_state_e      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [W-1:0]    data_q [2];
  logic [ID_W-1:0] id_q   [2];

  logic            pop, space, push;
  logic            wr0_new, wr1_new, shift;
  logic [ID_W-1:0] pick_id;
  logic [W-1:0]    push_data;

  assign pop   = (state_q != BUF_EMPTY) && rsp_ready;
  // A full buffer can still accept a word when its head leaves this cycle.
  assign space = (state_q != BUF_TWO) || pop;

  rr_pick5 u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .en_i  (rst_n && space),
    .gnt_o (gnt),
    .id_o  (pick_id),
    .any_o (push)
  );

  assign push_data = ~req_data[pick_id*W +: W];

  // Slot 0 is the head; slot 1 shifts forward when the head is popped from TWO.
  assign shift   = (state_q == BUF_TWO) && pop;
  assign wr0_new = push && ((state_q == BUF_EMPTY) || ((state_q == BUF_ONE) && pop));
  assign wr1_new = push && (((state_q == BUF_ONE) && !pop) || shift);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (push) ptr_d = (pick_id == CH_E) ? CH_A : pick_id + 1'b1;
    case (state_q)
      BUF_EMPTY: if (push)          state_d = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)           state_d = BUF_TWO;
        else if (pop && !push)      state_d = BUF_EMPTY;
      end
      BUF_TWO:   if (pop && !push)  state_d = BUF_ONE;
      default:                      state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BUF_EMPTY;
      ptr_q     <= CH_A;
      data_q[0] <= '0;
      data_q[1] <= '0;
      id_q[0]   <= '0;
      id_q[1]   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (wr0_new) begin
        data_q[0] <= push_data;
        id_q[0]   <= pick_id;
      end else if (shift) begin
        data_q[0] <= data_q[1];
        id_q[0]   <= id_q[1];
      end
      if (wr1_new) begin
        data_q[1] <= push_data;
        id_q[1]   <= pick_id;
      end
    end
  end

`ifdef INV_LANE_PARITY_EN
  logic par_q [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q[0] <= 1'b0;
      par_q[1] <= 1'b0;
    end else begin
      if (wr0_new)    par_q[0] <= ^push_data;
      else if (shift) par_q[0] <= par_q[1];
      if (wr1_new)    par_q[1] <= ^push_data;
    end
  end

  assign rsp_par = par_q[0];
`endif

  assign rsp_valid = (state_q != BUF_EMPTY);
  assign rsp_id    = id_q[0];
  assign rsp_data  = data_q[0];

endmodule

// File: tb/tb_inv_lane_arbiter.sv
// Self-checking bench for inv_lane_arbiter: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_inv_lane_arbiter;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [4:0]     req = '0;
  logic [5*W-1:0] req_data = '0;
  logic [4:0]     gnt;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [2:0]     rsp_id;
  logic [W-1:0]   rsp_data;
`ifdef INV_LANE_PARITY_EN
  logic           rsp_par;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inv_lane_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef INV_LANE_PARITY_EN
    ,
    .rsp_par   (rsp_par)
`endif
  );

  // Reference model: FIFO of pending responses plus the priority pointer.
  typedef struct {
    logic [2:0]   id;
    logic [W-1:0] data;
  } ent_t;
  ent_t mq[$];
  int   mptr;

  typedef struct {
    logic [4:0] req;
    logic       rdy;
    logic [4:0] gnt;
    logic       v;
    logic [2:0] id;
    logic [7:0] d;
  } vec_t;
  vec_t tv[15];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mptr = 0;
  endtask

  task automatic do_reset();
    req       = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_gnt", gnt, 5'b0);
    check("rst_id", rsp_id, 3'd0);
    check("rst_data", rsp_data, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // One clock: compare outputs with the model at the falling edge, then
  // advance the model across the rising edge.
  task automatic step(input string tag, output int win, output logic [4:0] g_seen);
    int         n;
    int         c;
    bit         pop;
    bit         space;
    logic [4:0] eg;
    ent_t       e;
    @(negedge clk);
    n     = mq.size();
    pop   = (n > 0) && rsp_ready;
    space = (n < 2) || pop;
    win   = -1;
    eg    = '0;
    if (space) begin
      for (int k = 0; k < 5; k++) begin
        c = (mptr + k) % 5;
        if (win < 0 && req[c]) win = c;
      end
    end
    if (win >= 0) eg[win] = 1'b1;
    g_seen = gnt;
    check({tag, "_gnt"}, gnt, eg);
    check({tag, "_valid"}, rsp_valid, n > 0);
    if (n > 0) begin
      check({tag, "_id"}, rsp_id, mq[0].id);
      check({tag, "_data"}, rsp_data, mq[0].data);
`ifdef INV_LANE_PARITY_EN
      check({tag, "_par"}, rsp_par, ^mq[0].data);
`endif
    end
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (win >= 0) begin
      e.id   = 3'(win);
      e.data = ~req_data[win*W +: W];
      mq.push_back(e);
      mptr = (win + 1) % 5;
    end
    #1;
  endtask

  initial begin
    int         win;
    logic [4:0] g;
    logic [4:0] eg;
    bit         pend[5];

    // Hand-derived vectors from reset; data A..E = 3C,22,33,44,55.
    tv[0]  = '{5'b00001, 1'b1, 5'b00001, 1'b0, 3'd0, 8'h00};
    tv[1]  = '{5'b00000, 1'b1, 5'b00000, 1'b1, 3'd0, 8'hC3};
    tv[2]  = '{5'b11111, 1'b1, 5'b00010, 1'b0, 3'd0, 8'h00};
    tv[3]  = '{5'b11101, 1'b1, 5'b00100, 1'b1, 3'd1, 8'hDD};
    tv[4]  = '{5'b11001, 1'b1, 5'b01000, 1'b1, 3'd2, 8'hCC};
    tv[5]  = '{5'b10001, 1'b1, 5'b10000, 1'b1, 3'd3, 8'hBB};
    tv[6]  = '{5'b00001, 1'b1, 5'b00001, 1'b1, 3'd4, 8'hAA};
    tv[7]  = '{5'b00110, 1'b0, 5'b00010, 1'b1, 3'd0, 8'hC3};
    tv[8]  = '{5'b00100, 1'b0, 5'b00000, 1'b1, 3'd0, 8'hC3};
    tv[9]  = '{5'b00100, 1'b0, 5'b00000, 1'b1, 3'd0, 8'hC3};
    tv[10] = '{5'b00100, 1'b1, 5'b00100, 1'b1, 3'd0, 8'hC3};
    tv[11] = '{5'b10000, 1'b1, 5'b10000, 1'b1, 3'd1, 8'hDD};
    tv[12] = '{5'b00000, 1'b1, 5'b00000, 1'b1, 3'd2, 8'hCC};
    tv[13] = '{5'b00000, 1'b1, 5'b00000, 1'b1, 3'd4, 8'hAA};
    tv[14] = '{5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 8'h00};

    do_reset();
    req_data = {8'h55, 8'h44, 8'h33, 8'h22, 8'h3C};
    for (int r = 0; r < 15; r++) begin
      req       = tv[r].req;
      rsp_ready = tv[r].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_gnt", r), gnt, tv[r].gnt);
      check($sformatf("vec%0d_valid", r), rsp_valid, tv[r].v);
      if (tv[r].v) begin
        check($sformatf("vec%0d_id", r), rsp_id, tv[r].id);
        check($sformatf("vec%0d_data", r), rsp_data, tv[r].d);
      end
      @(posedge clk);
      #1;
    end

    // All five requesting from reset: strict A..E rotation, one per cycle.
    do_reset();
    req_data  = {8'hE5, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    req       = 5'b11111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step("rr", win, g);
      eg = 5'b00001 << (k % 5);
      check("rr_order", g, eg);
    end

    // Fill to TWO under backpressure, then reset asynchronously mid-cycle.
    do_reset();
    req_data  = {8'h5A, 8'h4B, 8'h3C, 8'h2D, 8'h1E};
    rsp_ready = 1'b0;
    req       = 5'b00110;
    step("bp", win, g);
    req = 5'b00100;
    step("bp", win, g);
    req = 5'b01000;
    step("bp", win, g);
    check("bp_full_gnt", g, 5'b00000);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", rsp_valid, 1'b0);
    check("arst_gnt", gnt, 5'b00000);
    check("arst_id", rsp_id, 3'd0);
    check("arst_data", rsp_data, 8'h00);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    req       = 5'b11111;
    rsp_ready = 1'b1;
    step("post_rst", win, g);
    check("post_rst_first", g, 5'b00001);

`ifdef INV_LANE_PARITY_EN
    do_reset();
    rsp_ready = 1'b1;
    req       = 5'b00001;
    req_data  = '0;
    req_data[7:0] = 8'h01;
    step("par", win, g);
    check("par_data_fe", rsp_data, 8'hFE);
    check("par_one", rsp_par, 1'b1);
    req_data[7:0] = 8'h00;
    step("par", win, g);
    check("par_data_ff", rsp_data, 8'hFF);
    check("par_zero", rsp_par, 1'b0);
`endif

    // Randomized traffic: requests held until granted, random backpressure.
    do_reset();
    for (int i = 0; i < 5; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 5; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          req_data[i*W +: W] = W'($urandom);
        end
        req[i] = pend[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step("rnd", win, g);
      if (win >= 0) pend[win] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
